// File: rtl/booth_mult_ctrl.sv
// Sequential radix-2 Booth multiplier controller driving an external (2N+1)-bit adder.
// Optional macro BOOTH_MULT_ERR_EN adds an err flag for the most-negative multiplicand.
module booth_mult_ctrl #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N:0]   add_i1,
  output logic [2*N:0]   add_i2,
  input  logic [2*N:0]   add_sum,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
`ifdef BOOTH_MULT_ERR_EN
  ,
  output logic           err
`endif
);

  localparam int W  = 2*N + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N-1:0]  ONE_N    = N'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    p_reg;
  logic [N-1:0]    m_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    m_neg;
  logic [W-1:0]    p_next;
  logic [W-1:0]    addend;

  // Two's complement of M; wraps to itself for the most-negative value.
  assign m_neg = ~m_reg + ONE_N;

  // Booth pair {Q0, Q-1} selects add M, subtract M or nothing, aligned to A.
  always_comb begin
    addend = '0;
    case ({p_reg[1], p_reg[0]})
      2'b01:   addend = {m_reg, {(N+1){1'b0}}};
      2'b10:   addend = {m_neg, {(N+1){1'b0}}};
      default: addend = '0;
    endcase
  end

  assign add_i1 = (state_reg == CALC) ? p_reg  : '0;
  assign add_i2 = (state_reg == CALC) ? addend : '0;

  // Arithmetic right shift of the adder result; carry-out is simply dropped.
  generate
    for (genvar gi = 0; gi < W - 1; gi++) begin : g_shift
      assign p_next[gi] = add_sum[gi+1];
    end
  endgenerate
  assign p_next[W-1] = add_sum[W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      p_reg     <= '0;
      m_reg     <= '0;
      cnt_reg   <= '0;
      product   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BOOTH_MULT_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            m_reg     <= multiplicand;
            p_reg     <= {{N{1'b0}}, multiplier, 1'b0};
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= CALC;
`ifdef BOOTH_MULT_ERR_EN
            err       <= (multiplicand == {1'b1, {(N-1){1'b0}}});
`endif
          end
        end
        CALC: begin
          p_reg   <= p_next;
          cnt_reg <= cnt_reg + CNT_ONE;
          if (cnt_reg == CNT_LAST) begin
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          product   <= p_reg[W-1:1];
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed bench for booth_mult_ctrl with a behavioural model of the external adder.
module tb_booth_mult_ctrl;
  localparam int N = 5;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N:0]   add_i1;
  logic [2*N:0]   add_i2;
  logic [2*N:0]   add_sum;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
`ifdef BOOTH_MULT_ERR_EN
  logic           err;
`endif

  int checks = 0;
  int errors = 0;
  logic [2*N:0] a1_log [N];
  logic [2*N:0] a2_log [N];

  booth_mult_ctrl #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .add_i1       (add_i1),
    .add_i2       (add_i2),
    .add_sum      (add_sum),
    .busy         (busy),
    .done         (done),
    .product      (product)
`ifdef BOOTH_MULT_ERR_EN
    ,
    .err          (err)
`endif
  );

  // External adder: 11-bit sum, carry-out discarded.
  assign add_sum = add_i1 + add_i2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Starts a multiply at the current negedge and follows it to the product.
  task automatic run_mul(input string tag, input logic [N-1:0] m, input logic [N-1:0] q,
                         input logic [2*N-1:0] exp, input bit poke);
    int busy_n;
    int cyc;
    busy_n = 0;
    cyc = -1;
    multiplicand = m;
    multiplier = q;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < N) begin
        a1_log[i] = add_i1;
        a2_log[i] = add_i2;
      end
      if (busy) busy_n++;
      if (done) begin
        cyc = i;
        break;
      end
      if (poke && i == 2) begin
        start = 1'b1;
        multiplicand = 5'h07;
        multiplier = 5'h07;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(cyc), 32'(N));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(N + 1));
    @(negedge clk);
    chk({tag, " product"}, 32'(product), 32'(exp));
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset product", 32'(product), 32'd0);
    chk("reset add_i1", 32'(add_i1), 32'd0);
    chk("reset add_i2", 32'(add_i2), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_mul("3x5", 5'h03, 5'h05, 10'h00F, 1'b0);
    chk("3x5 add_i1_first", 32'(a1_log[0]), 32'h00A);

    run_mul("-3x5", 5'h1D, 5'h05, 10'h3F1, 1'b0);
    chk("-3x5 add_i2_s1", 32'(a2_log[0]), 32'h0C0);
    chk("-3x5 add_i2_s2", 32'(a2_log[1]), 32'h740);
    chk("-3x5 add_i2_s3", 32'(a2_log[2]), 32'h0C0);
    chk("-3x5 add_i2_s4", 32'(a2_log[3]), 32'h740);
    chk("-3x5 add_i2_s5", 32'(a2_log[4]), 32'h000);

    run_mul("15x-16", 5'h0F, 5'h10, 10'h310, 1'b0);
    run_mul("0x-1", 5'h00, 5'h1F, 10'h000, 1'b0);
    run_mul("2x3_poke", 5'h02, 5'h03, 10'h006, 1'b1);
    run_mul("3x-2_b2b", 5'h03, 5'h1E, 10'h3FA, 1'b0);

    // Reset in the third CALC cycle of a fresh multiply.
    multiplicand = 5'h05;
    multiplier = 5'h03;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst product", 32'(product), 32'd0);
    chk("midrst add_i1", 32'(add_i1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_mul("7x7", 5'h07, 5'h07, 10'h031, 1'b0);

`ifdef BOOTH_MULT_ERR_EN
    run_mul("-16x1", 5'h10, 5'h01, 10'h010, 1'b0);
    chk("-16x1 err", 32'(err), 32'd1);
    run_mul("2x2", 5'h02, 5'h02, 10'h004, 1'b0);
    chk("2x2 err", 32'(err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
